// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_pkg
// Description : Note codes, tone frequencies and jingle states shared by the
//               buzzer tone generators and the tone decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package tone_pkg;

  typedef enum logic [1:0] {
    NOTE_NONE = 2'd0,
    NOTE_DO   = 2'd1,
    NOTE_BB   = 2'd2,
    NOTE_SOL  = 2'd3
  } note_t;

  localparam int unsigned FREQ_DO  = 523;
  localparam int unsigned FREQ_BB  = 466;
  localparam int unsigned FREQ_SOL = 392;

  typedef enum logic [1:0] {
    J_IDLE = 2'd0,
    J_DO   = 2'd1,
    J_BB   = 2'd2
  } jingle_state_t;

  // Half-period in clock cycles, as seen by an edge-to-edge interval counter.
  function automatic int unsigned half_period_cycles(input int unsigned clk_hz,
                                                     input int unsigned freq_hz);
    return clk_hz / freq_hz / 2 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module      : period_meter
// Description : Synchronises a square wave, detects both edges and measures
//               the edge-to-edge interval with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module period_meter #(
  parameter int unsigned SILENCE_CYC = 262_143
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tone_in,
  output logic        edge_valid,
  output logic [17:0] interval,
  output logic        silent
);

  localparam logic [17:0] c_cnt_max = '1;
  localparam logic [17:0] c_silence = 18'(SILENCE_CYC);

  logic [1:0]  r_sync;
  logic        r_prev;
  logic [17:0] r_cnt;
  logic        r_armed;
  logic        w_edge;

  assign w_edge     = r_sync[1] ^ r_prev;
  assign edge_valid = w_edge & r_armed;
  assign interval   = r_cnt;
  // An edge restarts the counter, so it always wins over the silence check.
  assign silent     = r_armed & ~w_edge & (r_cnt == c_silence);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= 2'b00;
      r_prev  <= 1'b0;
      r_cnt   <= 18'd0;
      r_armed <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], tone_in};
      r_prev <= r_sync[1];
      if (w_edge) begin
        r_cnt   <= 18'd1;
        r_armed <= 1'b1;
      end else begin
        if (r_cnt != c_cnt_max) begin
          r_cnt <= r_cnt + 18'd1;
        end
        if (silent) begin
          r_armed <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tone_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tone_decoder
// Description : Classifies a square-wave tone as Do/Bb/Sol/none, reports the
//               debounced note and flags the Do->Bb->Sol kill jingle.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_decoder #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TOL_SHIFT   = 5,
  parameter int unsigned STABLE_N    = 4,
  parameter int unsigned SILENCE_CYC = 262_143
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tone_in,
  output logic [1:0]  note,
  output logic        note_valid,
  output logic        note_change,
  output logic        jingle_done,
  output logic [17:0] period
);
  import tone_pkg::*;

  localparam logic [17:0] c_nom_do  = 18'(half_period_cycles(CLK_HZ, FREQ_DO));
  localparam logic [17:0] c_nom_bb  = 18'(half_period_cycles(CLK_HZ, FREQ_BB));
  localparam logic [17:0] c_nom_sol = 18'(half_period_cycles(CLK_HZ, FREQ_SOL));
  localparam logic [17:0] c_do_lo   = c_nom_do  - (c_nom_do  >> TOL_SHIFT);
  localparam logic [17:0] c_do_hi   = c_nom_do  + (c_nom_do  >> TOL_SHIFT);
  localparam logic [17:0] c_bb_lo   = c_nom_bb  - (c_nom_bb  >> TOL_SHIFT);
  localparam logic [17:0] c_bb_hi   = c_nom_bb  + (c_nom_bb  >> TOL_SHIFT);
  localparam logic [17:0] c_sol_lo  = c_nom_sol - (c_nom_sol >> TOL_SHIFT);
  localparam logic [17:0] c_sol_hi  = c_nom_sol + (c_nom_sol >> TOL_SHIFT);
  localparam int unsigned           c_run_w   = $clog2(STABLE_N + 1);
  localparam logic [c_run_w-1:0]    c_run_max = c_run_w'(STABLE_N);
  localparam logic [c_run_w-1:0]    c_run_one = c_run_w'(1);

  logic                w_edge_valid;
  logic                w_silent;
  logic [17:0]         w_interval;
  note_t               w_class;
  note_t               r_note;
  note_t               r_cand;
  logic [c_run_w-1:0]  r_run;
  logic                r_note_valid;
  logic                r_note_change;
  logic [17:0]         r_period;
  jingle_state_t       r_jstate;
  jingle_state_t       w_jstate_nxt;
  logic                w_jingle_done;

  period_meter #(
    .SILENCE_CYC (SILENCE_CYC)
  ) u_meter (
    .clk        (clk),
    .reset      (reset),
    .tone_in    (tone_in),
    .edge_valid (w_edge_valid),
    .interval   (w_interval),
    .silent     (w_silent)
  );

  always_comb begin
    w_class = NOTE_NONE;
    if (w_interval >= c_do_lo && w_interval <= c_do_hi) begin
      w_class = NOTE_DO;
    end else if (w_interval >= c_bb_lo && w_interval <= c_bb_hi) begin
      w_class = NOTE_BB;
    end else if (w_interval >= c_sol_lo && w_interval <= c_sol_hi) begin
      w_class = NOTE_SOL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_note        <= NOTE_NONE;
      r_cand        <= NOTE_NONE;
      r_run         <= '0;
      r_note_valid  <= 1'b0;
      r_note_change <= 1'b0;
      r_period      <= 18'd0;
    end else begin
      r_note_change <= 1'b0;
      if (w_silent) begin
        r_cand        <= NOTE_NONE;
        r_run         <= '0;
        r_note        <= NOTE_NONE;
        r_note_valid  <= 1'b0;
        r_note_change <= (r_note != NOTE_NONE);
      end else begin
        if (w_edge_valid) begin
          r_period <= w_interval;
          if (w_class == r_cand) begin
            if (r_run != c_run_max) begin
              r_run <= r_run + c_run_one;
            end
          end else begin
            r_cand <= w_class;
            r_run  <= c_run_one;
          end
        end
        // Runs on the registered candidate, one cycle after the qualifying edge.
        if (r_run == c_run_max && r_cand != r_note) begin
          r_note        <= r_cand;
          r_note_valid  <= (r_cand != NOTE_NONE);
          r_note_change <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_jstate <= J_IDLE;
    end else begin
      r_jstate <= w_jstate_nxt;
    end
  end

  always_comb begin
    w_jstate_nxt  = r_jstate;
    w_jingle_done = 1'b0;
    if (r_note_change) begin
      if (r_note == NOTE_DO) begin
        w_jstate_nxt = J_DO;
      end else if (r_jstate == J_DO && r_note == NOTE_BB) begin
        w_jstate_nxt = J_BB;
      end else if (r_jstate == J_BB && r_note == NOTE_SOL) begin
        w_jstate_nxt  = J_IDLE;
        w_jingle_done = 1'b1;
      end else begin
        w_jstate_nxt = J_IDLE;
      end
    end
  end

  assign note        = r_note;
  assign note_valid  = r_note_valid;
  assign note_change = r_note_change;
  assign jingle_done = w_jingle_done;
  assign period      = r_period;

endmodule
`default_nettype wire

// File: tb/tb_tone_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_decoder
// Description : Directed bench for tone_decoder with a note-change scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_decoder;

  // CLK_HZ = 200 kHz: Do 192 (186..198), Bb 215 (209..221), Sol 256 (248..264)
  localparam int SIL   = 1000;
  localparam int D_DO  = 192;
  localparam int D_BB  = 215;
  localparam int D_SOL = 256;
  localparam int D_GAP = 203;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tone_in = 1'b0;
  logic [1:0]  note;
  logic        note_valid;
  logic        note_change;
  logic        jingle_done;
  logic [17:0] period;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int cyc;
    int note;
    int jd;
  } exp_t;
  exp_t exp_q[$];

  int m_last   = 0;
  int m_cand   = 0;
  int m_run    = 0;
  int m_note   = 0;
  int m_js     = 0;
  bit m_armed  = 1'b0;

  tone_decoder #(
    .CLK_HZ      (200_000),
    .TOL_SHIFT   (5),
    .STABLE_N    (4),
    .SILENCE_CYC (SIL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tone_in     (tone_in),
    .note        (note),
    .note_valid  (note_valid),
    .note_change (note_change),
    .jingle_done (jingle_done),
    .period      (period)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int classify(input int iv);
    if (iv >= 186 && iv <= 198) return 1;
    if (iv >= 209 && iv <= 221) return 2;
    if (iv >= 248 && iv <= 264) return 3;
    return 0;
  endfunction

  task automatic push_change(input int n, input int t);
    exp_t e;
    e.cyc  = t;
    e.note = n;
    e.jd   = (m_js == 2 && n == 3) ? 1 : 0;
    if (n == 1)                 m_js = 1;
    else if (m_js == 1 && n == 2) m_js = 2;
    else                        m_js = 0;
    m_note = n;
    exp_q.push_back(e);
  endtask

  task automatic model_edge();
    int iv;
    int cls;
    iv = cyc - m_last;
    m_last = cyc;
    if (!m_armed) begin
      m_armed = 1'b1;
    end else begin
      cls = classify(iv);
      if (cls == m_cand) begin
        if (m_run < 4) m_run++;
      end else begin
        m_cand = cls;
        m_run  = 1;
      end
      if (m_run == 4 && m_cand != m_note) push_change(m_cand, cyc + 4);
    end
  endtask

  // Toggle tone_in d cycles after the previous toggle.
  task automatic tog(input int d);
    repeat (m_last + d - cyc) @(posedge clk);
    #1 tone_in = ~tone_in;
    model_edge();
  endtask

  task automatic arm(input int n);
    m_last = cyc;
    tog(n);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic silence();
    if (m_note != 0) push_change(0, m_last + SIL + 3);
    m_armed = 1'b0;
    m_cand  = 0;
    m_run   = 0;
    repeat (SIL + 20) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b1 && (note_change === 1'b1 || jingle_done === 1'b1)) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_pulse cyc=%0d note=%0d nc=%0b jd=%0b expected=none",
               cyc, note, note_change, jingle_done);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("chg_cycle", cyc, e.cyc);
        chk("chg_note", note, e.note);
        chk("chg_valid", note_valid, (e.note != 0) ? 1 : 0);
        chk("chg_jingle", jingle_done, e.jd);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_note", note, 0);
    chk("rst_valid", note_valid, 0);
    chk("rst_change", note_change, 0);
    chk("rst_jingle", jingle_done, 0);
    chk("rst_period", period, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Do, then the full kill jingle with no gaps
    arm(10);
    for (int i = 0; i < 5; i++) tog(D_DO);
    settle();
    chk("do_period", period, D_DO);
    chk("do_note", note, 1);
    chk("do_valid", note_valid, 1);
    for (int i = 0; i < 5; i++) tog(D_BB);
    for (int i = 0; i < 5; i++) tog(D_SOL);
    settle();
    chk("jingle_note", note, 3);
    chk("jingle_period", period, D_SOL);

    // Silence forces note to none, then the next edge only re-arms
    silence();
    chk("sil_note", note, 0);
    chk("sil_valid", note_valid, 0);
    arm(30);
    settle();
    chk("rearm_period", period, D_SOL);

    // Between the Do and Bb windows
    for (int i = 0; i < 10; i++) tog(D_GAP);
    settle();
    chk("gap_note", note, 0);
    chk("gap_period", period, D_GAP);

    // Do then Sol: no jingle
    for (int i = 0; i < 5; i++) tog(D_DO);
    for (int i = 0; i < 5; i++) tog(D_SOL);
    settle();
    chk("dosol_note", note, 3);
    repeat (50) @(posedge clk);
    #2;
    chk("pre_rst_queue", exp_q.size(), 0);

    // Asynchronous reset mid-tone
    @(posedge clk);
    #3 reset = 1'b0;
    tone_in = 1'b0;
    #1;
    chk("mid_rst_note", note, 0);
    chk("mid_rst_valid", note_valid, 0);
    chk("mid_rst_change", note_change, 0);
    chk("mid_rst_jingle", jingle_done, 0);
    chk("mid_rst_period", period, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    m_armed = 1'b0;
    m_cand  = 0;
    m_run   = 0;
    m_note  = 0;
    m_js    = 0;
    arm(20);
    repeat (100) @(posedge clk);
    #2;
    chk("post_rst_period", period, 0);

    // Tolerance boundaries: +/-6 is Do, +7 is outside every window
    tog(D_DO);
    tog(D_DO + 6);
    tog(D_DO + 6);
    tog(D_DO - 6);
    tog(D_DO - 6);
    settle();
    chk("tol_in_note", note, 1);
    chk("tol_in_period", period, D_DO - 6);
    for (int i = 0; i < 4; i++) tog(D_DO + 7);
    settle();
    chk("tol_out_note", note, 0);
    chk("tol_out_period", period, D_DO + 7);

    repeat (20) @(posedge clk);
    #2;
    chk("end_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
